// File: rtl/soc_sysinfo_pkg.sv
// soc_sysinfo_pkg: register offsets, CAPS field positions and the CAPS word
// builder shared by the system-information slave and its uptime sub-block.
package soc_sysinfo_pkg;

  localparam int OFF_ID       = 0;
  localparam int OFF_TS       = 1;
  localparam int OFF_CAPS     = 2;
  localparam int OFF_UPT_LO   = 3;
  localparam int OFF_UPT_HI   = 4;
  localparam int OFF_SCRATCH0 = 5;

  localparam int CAPS_UPT_BIT  = 0;
  localparam int CAPS_NSCR_LSB = 8;
  localparam int CAPS_HWV_LSB  = 16;

  // Assemble the capability word; unused bits [7:1] stay zero.
  function automatic logic [31:0] caps_word(input logic [15:0] hwv,
                                            input int nscr,
                                            input logic upt);
    logic [31:0] w;
    w = '0;
    w[CAPS_HWV_LSB +: 16] = hwv;
    w[CAPS_NSCR_LSB +: 8] = 8'(nscr);
    w[CAPS_UPT_BIT]       = upt;
    return w;
  endfunction

endpackage

// File: rtl/soc_sysinfo_uptime.sv
// soc_sysinfo_uptime: free-running 64-bit uptime counter with a 32-bit shadow
// of the high word, captured atomically when the low word is read.
// Only instantiated when SYSINFO_UPTIME_EN is defined.
module soc_sysinfo_uptime (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        capture,
  output logic [31:0] lo,
  output logic [31:0] hi_shadow
);

  logic [63:0] r_cnt;
  logic [31:0] r_shadow;

  // Counter: +1 every clock, wraps silently; a clear forces it back to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else            r_cnt <= r_cnt + 64'd1;
  end

  // Shadow: takes the high word sampled together with the low-word read;
  // a simultaneous clear wins so software never sees a stale high word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_shadow <= '0;
    else if (clear)   r_shadow <= '0;
    else if (capture) r_shadow <= r_cnt[63:32];
  end

  assign lo        = r_cnt[31:0];
  assign hi_shadow = r_shadow;

endmodule

// File: rtl/soc_sysinfo.sv
// soc_sysinfo: Avalon-MM system-information slave (ID, build timestamp, CAPS,
// scratch words, registered read path with readdatavalid, latency 1).
// Define SYSINFO_UPTIME_EN to add the 64-bit uptime counter at offsets 3/4.
module soc_sysinfo
  import soc_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYS_ID        = 32'h0000_0000,
  parameter logic [31:0] BUILD_TS      = 32'h0000_0000,
  parameter logic [15:0] HW_VERSION    = 16'h0001,
  parameter int          ADDR_W        = 3,
  parameter int          NUM_SCRATCH   = 2,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  // Keep the array legal when no scratch words are requested.
  localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

`ifdef SYSINFO_UPTIME_EN
  localparam logic UPT_PRESENT = 1'b1;
`else
  localparam logic UPT_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS_VAL = caps_word(HW_VERSION, NUM_SCRATCH, UPT_PRESENT);

  logic [31:0] r_scratch [SCR_N];
  logic [31:0] w_rdata;

`ifdef SYSINFO_UPTIME_EN
  logic        w_hit_upt_lo;
  logic        w_clear;
  logic        w_capture;
  logic [31:0] w_upt_lo;
  logic [31:0] w_upt_hi;

  assign w_hit_upt_lo = (address == ADDR_W'(OFF_UPT_LO));
  assign w_clear      = write && w_hit_upt_lo && writedata[0];
  assign w_capture    = read && w_hit_upt_lo;

  soc_sysinfo_uptime u_uptime (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (w_clear),
    .capture   (w_capture),
    .lo        (w_upt_lo),
    .hi_shadow (w_upt_hi)
  );
`endif

  // Scratch words: full 32-bit writes; offsets outside the range are ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SCR_N; i++) r_scratch[i] <= SCRATCH_RESET;
    end else if (write) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (address == ADDR_W'(OFF_SCRATCH0 + i)) r_scratch[i] <= writedata;
      end
    end
  end

  // Read mux: pre-write values of every register; unmapped offsets read 0.
  always_comb begin
    w_rdata = '0;
    if (address == ADDR_W'(OFF_ID))        w_rdata = SYS_ID;
    else if (address == ADDR_W'(OFF_TS))   w_rdata = BUILD_TS;
    else if (address == ADDR_W'(OFF_CAPS)) w_rdata = CAPS_VAL;
`ifdef SYSINFO_UPTIME_EN
    else if (w_hit_upt_lo)                 w_rdata = w_upt_lo;
    else if (address == ADDR_W'(OFF_UPT_HI)) w_rdata = w_upt_hi;
`endif
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (address == ADDR_W'(OFF_SCRATCH0 + i)) w_rdata = r_scratch[i];
    end
  end

  // Output register: one valid per sampled read; data holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= w_rdata;
    end
  end

endmodule
